// File: rtl/enc_bram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// enc_bram_arbiter_pkg
// Shared constants for the encryption-path BRAM arbiter and its neighbours
// (reader, writer, AES wrapper):
//   REQ_WR / REQ_RD          requester indices
//   DEFAULT_ADDR_WIDTH       default BRAM word-address width
//   DEFAULT_DATA_WIDTH       default BRAM word width (one AES block)
//   arb_grant()              two-requester grant resolution helper
// ---------------------------------------------------------------------------
package enc_bram_arbiter_pkg;

   localparam logic REQ_WR = 1'b0;
   localparam logic REQ_RD = 1'b1;

   localparam int DEFAULT_ADDR_WIDTH = 10;
   localparam int DEFAULT_DATA_WIDTH = 128;

   // Returns {rd_grant, wr_grant}, one-hot or zero. A lone requester always
   // wins; on contention the requester named by 'favour' wins.
   function automatic logic [1:0] arb_grant(input logic w_req,
                                            input logic r_req,
                                            input logic favour);
      logic [1:0] gnt;
      gnt = 2'b00;
      if (w_req && (!r_req || (favour == REQ_WR))) begin
         gnt = 2'b01;
      end else if (r_req) begin
         gnt = 2'b10;
      end else begin
         gnt = 2'b00;
      end
      return gnt;
   endfunction

endpackage

// File: rtl/enc_bram_rd_pipe.sv
// ---------------------------------------------------------------------------
// enc_bram_rd_pipe
// Read-return path. A read issue (registered BRAM enable without write
// enable) is shifted through an RD_LAT-deep valid pipeline so that r_dvalid_o
// lines up with the cycle the BRAM presents the data. No stall capability.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rd_issue_i        read command currently driven on the BRAM port
//   bram_dout_i       BRAM read data
//   r_dvalid_o        read data valid (one pulse per issued read)
//   r_dout_o          read data; follows bram_dout_i while valid, else holds
// ---------------------------------------------------------------------------
module enc_bram_rd_pipe #(
   parameter int RD_LAT     = 1,
   parameter int DATA_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_issue_i,
   input  logic [DATA_WIDTH-1:0] bram_dout_i,
   output logic                  r_dvalid_o,
   output logic [DATA_WIDTH-1:0] r_dout_o
);

   logic [RD_LAT-1:0]     valid_q, valid_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  valid_out_s;

   assign valid_out_s = valid_q[RD_LAT-1];

   // Valid shift pipeline and read-data hold register next state.
   always_comb begin
      valid_d    = '0;
      valid_d[0] = rd_issue_i;
      for (int i = 1; i < RD_LAT; i++) begin
         valid_d[i] = valid_q[i-1];
      end
      if (valid_out_s) begin
         dout_d = bram_dout_i;
      end else begin
         dout_d = dout_q;
      end
   end

   // Pipeline state; an async reset drops every in-flight read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dout_q  <= '0;
      end else begin
         valid_q <= valid_d;
         dout_q  <= dout_d;
      end
   end

   // The BRAM data is only valid in the pulse cycle itself, so it is passed
   // straight through then and held from the register afterwards.
   assign r_dvalid_o = valid_out_s;
   assign r_dout_o   = valid_out_s ? bram_dout_i : dout_q;

endmodule

// File: rtl/enc_bram_arbiter.sv
// ---------------------------------------------------------------------------
// enc_bram_arbiter
// Arbitrates one BRAM port between a block writer and a readback reader.
// Grants are combinational and one-hot; the winning command is registered
// onto the BRAM port for exactly one cycle. Reads return through
// enc_bram_rd_pipe RD_LAT+1 cycles after their grant, in grant order.
// Optional feature macro: BRAM_ARB_RR_EN -- round-robin on contention
// (default build: fixed writer priority).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   w_req/w_addr/w_din, w_gnt       writer request, address, data, grant
//   r_req/r_addr, r_gnt             reader request, address, grant
//   r_dout, r_dvalid                read data and its valid pulse
//   bram_en/we/addr/din, bram_dout  BRAM port
//   wr_cnt, rd_cnt                  granted write/read counters (mod 2^16)
// ---------------------------------------------------------------------------
module enc_bram_arbiter
   import enc_bram_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int RD_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  w_req,
   input  logic [ADDR_WIDTH-1:0] w_addr,
   input  logic [DATA_WIDTH-1:0] w_din,
   output logic                  w_gnt,
   input  logic                  r_req,
   input  logic [ADDR_WIDTH-1:0] r_addr,
   output logic                  r_gnt,
   output logic [DATA_WIDTH-1:0] r_dout,
   output logic                  r_dvalid,
   output logic                  bram_en,
   output logic                  bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_din,
   input  logic [DATA_WIDTH-1:0] bram_dout,
   output logic [15:0]           wr_cnt,
   output logic [15:0]           rd_cnt
);

   logic [1:0]            grant_s;
   logic                  favour_s;
   logic                  bram_en_q, bram_en_d;
   logic                  bram_we_q, bram_we_d;
   logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
   logic [DATA_WIDTH-1:0] bram_din_q, bram_din_d;
   logic [15:0]           wr_cnt_q, wr_cnt_d;
   logic [15:0]           rd_cnt_q, rd_cnt_d;

`ifdef BRAM_ARB_RR_EN
   // favour_q names the requester NOT granted most recently; it is the
   // one that wins the next contention. Cleared to REQ_WR so the writer
   // wins the first contention after reset.
   logic favour_q, favour_d;

   // Round-robin pointer next state.
   always_comb begin
      favour_d = favour_q;
      if (grant_s[0]) begin
         favour_d = REQ_RD;
      end else if (grant_s[1]) begin
         favour_d = REQ_WR;
      end else begin
         favour_d = favour_q;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         favour_q <= REQ_WR;
      end else begin
         favour_q <= favour_d;
      end
   end

   assign favour_s = favour_q;
`else
   assign favour_s = REQ_WR;
`endif

   assign grant_s = arb_grant(w_req, r_req, favour_s);

   // Grants are visible outputs and are forced low while reset is asserted.
   // Internal state uses the ungated grant: it is held in reset anyway.
   assign w_gnt = rst_n & grant_s[0];
   assign r_gnt = rst_n & grant_s[1];

   // BRAM command and counter next state. Address/data hold when idle;
   // write data is only loaded on writer grants.
   always_comb begin
      bram_en_d   = grant_s[0] | grant_s[1];
      bram_we_d   = grant_s[0];
      bram_addr_d = bram_addr_q;
      bram_din_d  = bram_din_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      if (grant_s[0]) begin
         bram_addr_d = w_addr;
         bram_din_d  = w_din;
         wr_cnt_d    = wr_cnt_q + 16'd1;
      end else if (grant_s[1]) begin
         bram_addr_d = r_addr;
         rd_cnt_d    = rd_cnt_q + 16'd1;
      end else begin
         bram_addr_d = bram_addr_q;
         bram_din_d  = bram_din_q;
      end
   end

   // BRAM command and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bram_en_q   <= 1'b0;
         bram_we_q   <= 1'b0;
         bram_addr_q <= '0;
         bram_din_q  <= '0;
         wr_cnt_q    <= 16'd0;
         rd_cnt_q    <= 16'd0;
      end else begin
         bram_en_q   <= bram_en_d;
         bram_we_q   <= bram_we_d;
         bram_addr_q <= bram_addr_d;
         bram_din_q  <= bram_din_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
      end
   end

   assign bram_en   = bram_en_q;
   assign bram_we   = bram_we_q;
   assign bram_addr = bram_addr_q;
   assign bram_din  = bram_din_q;
   assign wr_cnt    = wr_cnt_q;
   assign rd_cnt    = rd_cnt_q;

   // The read pipe starts from the registered command, so it only needs
   // RD_LAT stages to meet the BRAM data.
   enc_bram_rd_pipe #(
      .RD_LAT     (RD_LAT),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rd_pipe (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_issue_i  (bram_en_q & ~bram_we_q),
      .bram_dout_i (bram_dout),
      .r_dvalid_o  (r_dvalid),
      .r_dout_o    (r_dout)
   );

endmodule

// File: tb/tb_enc_bram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_enc_bram_arbiter
// Directed bench for enc_bram_arbiter with RD_LAT=2 and a behavioural BRAM.
// Inputs are driven 1 ns after the rising edge, outputs sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_enc_bram_arbiter;

   localparam int AW     = 10;
   localparam int DW     = 128;
   localparam int RD_LAT = 2;
`ifdef BRAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          w_req, r_req;
   logic [AW-1:0] w_addr, r_addr;
   logic [DW-1:0] w_din;
   logic          w_gnt, r_gnt, r_dvalid;
   logic [DW-1:0] r_dout;
   logic          bram_en, bram_we;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_din, bram_dout;
   logic [15:0]   wr_cnt, rd_cnt;

   int n_chk  = 0;
   int n_pass = 0;
   int exp_wr = 0;
   int exp_rd = 0;

   always #5 clk = ~clk;

   enc_bram_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RD_LAT     (RD_LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .w_req     (w_req),
      .w_addr    (w_addr),
      .w_din     (w_din),
      .w_gnt     (w_gnt),
      .r_req     (r_req),
      .r_addr    (r_addr),
      .r_gnt     (r_gnt),
      .r_dout    (r_dout),
      .r_dvalid  (r_dvalid),
      .bram_en   (bram_en),
      .bram_we   (bram_we),
      .bram_addr (bram_addr),
      .bram_din  (bram_din),
      .bram_dout (bram_dout),
      .wr_cnt    (wr_cnt),
      .rd_cnt    (rd_cnt)
   );

   // Behavioural BRAM: two-stage read (RD_LAT=2), address 5 preloaded in reset.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] rd_s1 = '0;
   logic [DW-1:0] rd_s2 = '0;
   assign bram_dout = rd_s2;

   always @(posedge clk) begin
      if (!rst_n) mem[5] <= 128'h55;
      else if (bram_en && bram_we) mem[bram_addr] <= bram_din;
      if (bram_en && !bram_we) rd_s1 <= mem[bram_addr];
      rd_s2 <= rd_s1;
   end

   task automatic chk_eq(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic exp_w;
      logic seen;
      rst_n  = 1'b0;
      w_req  = 1'b1;
      r_req  = 1'b1;
      w_addr = 10'd1;
      r_addr = 10'd2;
      w_din  = 128'h1234;

      // Reset state with both requests high.
      #3;
      chk_eq("rst_w_gnt", w_gnt, 1'b0);
      chk_eq("rst_r_gnt", r_gnt, 1'b0);
      chk_eq("rst_dvalid", r_dvalid, 1'b0);
      chk_eq("rst_bram_en", bram_en, 1'b0);
      chk_eq("rst_bram_addr", bram_addr, 10'd0);
      chk_eq("rst_r_dout", r_dout, 128'h0);
      chk_eq("rst_wr_cnt", wr_cnt, 16'd0);
      cyc();
      cyc();
      rst_n = 1'b1;
      w_req = 1'b0;
      r_req = 1'b0;

      // Writer alone: addr 0..3, data A0..A3.
      for (int i = 0; i < 4; i++) begin
         cyc();
         w_req  = 1'b1;
         w_addr = AW'(i);
         w_din  = 128'hA0 + DW'(i);
         #1;
         chk_eq("wr_w_gnt", w_gnt, 1'b1);
         chk_eq("wr_r_gnt", r_gnt, 1'b0);
         if (i > 0) begin
            chk_eq("wr_bram_we", bram_we, 1'b1);
            chk_eq("wr_bram_addr", bram_addr, AW'(i - 1));
         end
         exp_wr++;
      end
      cyc();
      w_req = 1'b0;
      #1;
      chk_eq("wr_w_gnt_off", w_gnt, 1'b0);
      chk_eq("wr_bram_we3", bram_we, 1'b1);
      chk_eq("wr_bram_addr3", bram_addr, 10'd3);
      chk_eq("wr_bram_din3", bram_din, 128'hA3);
      cyc();
      chk_eq("wr_idle_en", bram_en, 1'b0);
      chk_eq("wr_idle_we", bram_we, 1'b0);
      chk_eq("wr_addr_hold", bram_addr, 10'd3);
      chk_eq("wr_cnt4", wr_cnt, 16'd4);

      // Read alone at addr 5: data 0x55, valid exactly 3 cycles after grant.
      cyc();
      r_req  = 1'b1;
      r_addr = 10'd5;
      #1;
      chk_eq("rd_r_gnt", r_gnt, 1'b1);
      chk_eq("rd_w_gnt", w_gnt, 1'b0);
      exp_rd++;
      for (int k = 1; k <= 4; k++) begin
         cyc();
         r_req = 1'b0;
         #1;
         if (k == 1) begin
            chk_eq("rd_bram_en", bram_en, 1'b1);
            chk_eq("rd_bram_we", bram_we, 1'b0);
            chk_eq("rd_bram_addr", bram_addr, 10'd5);
         end
         chk_eq($sformatf("rd_dvalid_t%0d", k), r_dvalid, (k == 3));
         if (k == 3) chk_eq("rd_dout", r_dout, 128'h55);
      end
      chk_eq("rd_dout_hold", r_dout, 128'h55);
      chk_eq("rd_cnt1", rd_cnt, 16'd1);

      // Contention for 4 cycles, then writer drops.
      w_addr = 10'd8;
      w_din  = 128'h88;
      r_addr = 10'd9;
      for (int i = 0; i < 4; i++) begin
         cyc();
         w_req = 1'b1;
         r_req = 1'b1;
         #1;
         exp_w = RR ? (i % 2 == 0) : 1'b1;
         chk_eq($sformatf("cont_w%0d", i), w_gnt, exp_w);
         chk_eq($sformatf("cont_r%0d", i), r_gnt, !exp_w);
         if (exp_w) exp_wr++;
         else exp_rd++;
      end
      cyc();
      w_req = 1'b0;
      #1;
      chk_eq("cont_r_alone", r_gnt, 1'b1);
      chk_eq("cont_w_off", w_gnt, 1'b0);
      exp_rd++;
      cyc();
      r_req = 1'b0;
      repeat (4) cyc();
      chk_eq("cont_wr_cnt", wr_cnt, 16'(exp_wr));
      chk_eq("cont_rd_cnt", rd_cnt, 16'(exp_rd));

      // Write 0xBEEF to addr 7, read it back on the next grant.
      cyc();
      w_req  = 1'b1;
      w_addr = 10'd7;
      w_din  = 128'hBEEF;
      #1;
      chk_eq("raw_w_gnt", w_gnt, 1'b1);
      exp_wr++;
      cyc();
      w_req  = 1'b0;
      r_req  = 1'b1;
      r_addr = 10'd7;
      #1;
      chk_eq("raw_r_gnt", r_gnt, 1'b1);
      exp_rd++;
      for (int k = 1; k <= 3; k++) begin
         cyc();
         r_req = 1'b0;
         #1;
         chk_eq($sformatf("raw_dvalid_t%0d", k), r_dvalid, (k == 3));
         if (k == 3) chk_eq("raw_dout", r_dout, 128'hBEEF);
      end
      chk_eq("raw_wr_cnt", wr_cnt, 16'(exp_wr));
      chk_eq("raw_rd_cnt", rd_cnt, 16'(exp_rd));

      // Three back-to-back reads, reset before the first return.
      for (int g = 0; g < 3; g++) begin
         cyc();
         r_req  = 1'b1;
         r_addr = AW'(g + 1);
         #1;
         chk_eq($sformatf("b2b_r_gnt%0d", g), r_gnt, 1'b1);
      end
      #1;
      rst_n = 1'b0;
      #1;
      chk_eq("mid_rst_r_gnt", r_gnt, 1'b0);
      chk_eq("mid_rst_w_gnt", w_gnt, 1'b0);
      chk_eq("mid_rst_dvalid", r_dvalid, 1'b0);
      chk_eq("mid_rst_en", bram_en, 1'b0);
      chk_eq("mid_rst_we", bram_we, 1'b0);
      chk_eq("mid_rst_addr", bram_addr, 10'd0);
      chk_eq("mid_rst_din", bram_din, 128'h0);
      chk_eq("mid_rst_dout", r_dout, 128'h0);
      chk_eq("mid_rst_rd_cnt", rd_cnt, 16'd0);
      chk_eq("mid_rst_wr_cnt", wr_cnt, 16'd0);
      cyc();
      rst_n = 1'b1;
      r_req = 1'b0;
      seen  = 1'b0;
      for (int k = 0; k < 6; k++) begin
         cyc();
         if (r_dvalid) seen = 1'b1;
      end
      chk_eq("post_rst_no_dvalid", seen, 1'b0);
      chk_eq("post_rst_rd_cnt", rd_cnt, 16'd0);

      // 65536 write grants: wr_cnt wraps to 0.
      cyc();
      w_req  = 1'b1;
      w_addr = 10'd0;
      w_din  = 128'h0;
      repeat (65535) @(posedge clk);
      #1;
      chk_eq("wrap_ffff", wr_cnt, 16'hFFFF);
      cyc();
      w_req = 1'b0;
      chk_eq("wrap_zero", wr_cnt, 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
